// File: rtl/match_sequencer.sv
// Match-level controller for the pong datapath: serve timing, step strobes,
// goal counting, pause and game-over handling. All outputs are registered.
module match_sequencer #(
  parameter int unsigned STEP_DIV     = 4,
  parameter int unsigned SERVE_CYCLES = 64,
  parameter int unsigned PAUSE_CYCLES = 32,
  parameter int unsigned WIN_SCORE    = 10
) (
  input  logic       GAME_CLK,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       goal_player,
  input  logic       goal_com,
  output logic       play_en,
  output logic       ball_center,
  output logic       serve_dir,
  output logic [3:0] player_score,
  output logic [3:0] com_score,
  output logic [2:0] state,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_POINT  = 3'd4,
    S_OVER   = 3'd5
  } state_e;

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_CYCLES - 1);
  localparam logic [7:0] POINT_LOAD = 8'(PAUSE_CYCLES - 1);
  localparam logic [7:0] STEP_LAST  = 8'(STEP_DIV - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [1:0] WIN_PLAYER = 2'b01;
  localparam logic [1:0] WIN_COM    = 2'b10;

  state_e     state_q, state_d;
  logic       play_en_q, play_en_d;
  logic       ball_center_q, ball_center_d;
  logic       serve_dir_q, serve_dir_d;
  logic [3:0] player_score_q, player_score_d;
  logic [3:0] com_score_q, com_score_d;
  logic       game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] step_q, step_d;
  logic [7:0] delay_q, delay_d;
  logic       start_q, pause_q;

  logic       start_edge, pause_edge;
  logic [3:0] player_inc, com_inc;

  assign start_edge = start_btn & ~start_q;
  assign pause_edge = pause_btn & ~pause_q;
  assign player_inc = player_score_q + 4'd1;
  assign com_inc    = com_score_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    play_en_d      = 1'b0;
    ball_center_d  = 1'b0;
    serve_dir_d    = serve_dir_q;
    player_score_d = player_score_q;
    com_score_d    = com_score_q;
    game_over_d    = game_over_q;
    winner_d       = winner_q;
    step_d         = step_q;
    delay_d        = delay_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_d        = S_SERVE;
          player_score_d = 4'd0;
          com_score_d    = 4'd0;
          winner_d       = 2'b00;
          game_over_d    = 1'b0;
          serve_dir_d    = 1'b1;
          ball_center_d  = 1'b1;
          delay_d        = SERVE_LOAD;
        end
      end
      S_SERVE: begin
        if (delay_q == 8'd0) begin
          state_d = S_PLAY;
          step_d  = 8'd0;
        end else begin
          delay_d = delay_q - 8'd1;
        end
      end
      S_PLAY: begin
        // Goals outrank pause; goal_player outranks goal_com.
        if (goal_player) begin
          player_score_d = player_inc;
          serve_dir_d    = 1'b1;
          if (player_inc == WIN) begin
            state_d     = S_OVER;
            winner_d    = WIN_PLAYER;
            game_over_d = 1'b1;
          end else begin
            state_d = S_POINT;
            delay_d = POINT_LOAD;
          end
        end else if (goal_com) begin
          com_score_d = com_inc;
          serve_dir_d = 1'b0;
          if (com_inc == WIN) begin
            state_d     = S_OVER;
            winner_d    = WIN_COM;
            game_over_d = 1'b1;
          end else begin
            state_d = S_POINT;
            delay_d = POINT_LOAD;
          end
        end else if (pause_edge) begin
          state_d = S_PAUSED;
        end else if (step_q == STEP_LAST) begin
          step_d    = 8'd0;
          play_en_d = 1'b1;
        end else begin
          step_d = step_q + 8'd1;
        end
      end
      S_PAUSED: begin
        if (pause_edge) state_d = S_PLAY;
      end
      S_POINT: begin
        if (delay_q == 8'd0) begin
          state_d       = S_SERVE;
          ball_center_d = 1'b1;
          delay_d       = SERVE_LOAD;
        end else begin
          delay_d = delay_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge GAME_CLK) begin
    if (reset) begin
      state_q        <= S_IDLE;
      play_en_q      <= 1'b0;
      ball_center_q  <= 1'b0;
      serve_dir_q    <= 1'b1;
      player_score_q <= 4'd0;
      com_score_q    <= 4'd0;
      game_over_q    <= 1'b0;
      winner_q       <= 2'b00;
      step_q         <= 8'd0;
      delay_q        <= 8'd0;
      start_q        <= 1'b0;
      pause_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      play_en_q      <= play_en_d;
      ball_center_q  <= ball_center_d;
      serve_dir_q    <= serve_dir_d;
      player_score_q <= player_score_d;
      com_score_q    <= com_score_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
      step_q         <= step_d;
      delay_q        <= delay_d;
      start_q        <= start_btn;
      pause_q        <= pause_btn;
    end
  end

  assign play_en      = play_en_q;
  assign ball_center  = ball_center_q;
  assign serve_dir    = serve_dir_q;
  assign player_score = player_score_q;
  assign com_score    = com_score_q;
  assign state        = state_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;

endmodule
